// File: rtl/seg7_scan_if.sv
// Bus between the datapath and the 7-segment scan driver.
interface seg7_scan_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   data_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     blank_in;
    logic                    lz_en;
    logic [6:0]              a_to_g;
    logic                    dp;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_start;

    modport master (
        output load, data_in, dp_in, blank_in, lz_en,
        input  a_to_g, dp, an, frame_start
    );

    modport slave (
        input  load, data_in, dp_in, blank_in, lz_en,
        output a_to_g, dp, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment driver: time-sliced anodes with dead time,
// blanking, decimal points, leading-zero suppression and a frame-aligned shadow.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned SLOT_CYC       = 50000,
    parameter int unsigned DEAD_CYC       = 500,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int unsigned CNT_W  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int unsigned IDX_W  = $clog2(N_DIGITS);
    localparam int unsigned DATA_W = 4 * N_DIGITS;

    localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic                into_frame_c;

    logic [DATA_W-1:0]   pend_data_q, pend_data_n, shd_data_q, shd_data_n;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_n, shd_dp_q, shd_dp_n;
    logic [N_DIGITS-1:0] pend_blank_q, pend_blank_n, shd_blank_q, shd_blank_n;

    logic [N_DIGITS-1:0] supp_c;
    logic                zero_run_c;
    logic [3:0]          nib_c;
    logic                sel_dp_c, sel_blank_c, sel_supp_c;
    logic [6:0]          seg_low_c, seg_c;
    logic                dp_c;
    logic [N_DIGITS-1:0] an_hi_c, an_c;

    logic [6:0]          a_to_g_q;
    logic                dp_q;
    logic [N_DIGITS-1:0] an_q;
    logic                frame_start_q;

    // Hex to segments, active-low form, a in bit 6 .. g in bit 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    // Scan sequencing: idle holds until reset release, then slot counter and digit index.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        idx_n        = idx_q;
        into_frame_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_n      = ST_RUN;
                cnt_n        = '0;
                idx_n        = '0;
                into_frame_c = 1'b1;
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(SLOT_CYC - 1)) begin
                    cnt_n = '0;
                    if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                        idx_n        = '0;
                        into_frame_c = 1'b1;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Pending capture and frame-aligned shadow commit; a load at the boundary lands directly.
    always_comb begin
        pend_data_n  = pend_data_q;
        pend_dp_n    = pend_dp_q;
        pend_blank_n = pend_blank_q;
        shd_data_n   = shd_data_q;
        shd_dp_n     = shd_dp_q;
        shd_blank_n  = shd_blank_q;
        if (bus.load) begin
            pend_data_n  = bus.data_in;
            pend_dp_n    = bus.dp_in;
            pend_blank_n = bus.blank_in;
        end
        if (bus.load && (into_frame_c || frame_start_q)) begin
            shd_data_n  = bus.data_in;
            shd_dp_n    = bus.dp_in;
            shd_blank_n = bus.blank_in;
        end else if (into_frame_c) begin
            shd_data_n  = pend_data_q;
            shd_dp_n    = pend_dp_q;
            shd_blank_n = pend_blank_q;
        end
    end

    // Display value for the coming cycle, so outputs are valid on the slot's first cycle.
    always_comb begin
        supp_c      = '0;
        zero_run_c  = 1'b1;
        nib_c       = 4'h0;
        sel_dp_c    = 1'b0;
        sel_blank_c = 1'b0;
        sel_supp_c  = 1'b0;
        an_hi_c     = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run_c = zero_run_c & (shd_data_n[4*k +: 4] == 4'h0);
            supp_c[k]  = zero_run_c & bus.lz_en;
        end
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_n == IDX_W'(k)) begin
                nib_c       = shd_data_n[4*k +: 4];
                sel_dp_c    = shd_dp_n[k];
                sel_blank_c = shd_blank_n[k];
                sel_supp_c  = supp_c[k];
                if (cnt_n >= CNT_W'(DEAD_CYC)) begin
                    an_hi_c[k] = 1'b1;
                end
            end
        end
        seg_low_c = (sel_blank_c || sel_supp_c) ? 7'h7F : hex_to_seg(nib_c);
        seg_c     = (SEG_ACTIVE_LOW != 0) ? seg_low_c : ~seg_low_c;
        dp_c      = (sel_dp_c && !sel_blank_c) ? ~DP_OFF : DP_OFF;
        an_c      = (AN_ACTIVE_LOW != 0) ? ~an_hi_c : an_hi_c;
    end

    // Sequencer and shadow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            shd_data_q   <= '0;
            shd_dp_q     <= '0;
            shd_blank_q  <= '0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            idx_q        <= idx_n;
            pend_data_q  <= pend_data_n;
            pend_dp_q    <= pend_dp_n;
            pend_blank_q <= pend_blank_n;
            shd_data_q   <= shd_data_n;
            shd_dp_q     <= shd_dp_n;
            shd_blank_q  <= shd_blank_n;
        end
    end

    // Registered pin drive; inactive levels while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_to_g_q      <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            a_to_g_q      <= seg_c;
            dp_q          <= dp_c;
            an_q          <= an_c;
            frame_start_q <= into_frame_c;
        end
    end

    assign bus.a_to_g      = a_to_g_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;
endmodule
